// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared types and constants for the dcache write-back buffer
package cache_defs;

  localparam int WBB_DEPTH  = 4;
  localparam int WBB_ADDR_W = 32;
  localparam int WBB_LINE_W = 128;
  localparam int WBB_OFF_W  = 4;

  typedef struct packed {
    logic                             valid;
    logic [WBB_ADDR_W-WBB_OFF_W-1:0]  line_addr;
    logic [WBB_LINE_W-1:0]            data;
  } wbb_entry_s;

  typedef enum logic {
    WBB_IDLE = 1'b0,
    WBB_BUSY = 1'b1
  } wbb_state_e;

endpackage

// File: rtl/wbb_match.sv
// rtl/wbb_match.sv - DEPTH-way line-address comparator with lock mask
module wbb_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 28,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0]            lock_i,
  output logic [DEPTH-1:0]            match_o,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        locked_hit_o
);

  logic [DEPTH-1:0] raw;

  // Compare against every valid entry; split unlocked matches from the locked head
  always_comb begin
    raw   = '0;
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      raw[i] = valid_i[i] && (tags_i[i] == tag_i);
    end
    match_o      = raw & ~lock_i;
    locked_hit_o = |(raw & lock_i);
    hit_o        = |match_o;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// rtl/dcache_wb_buffer.sv - write-back buffer draining evicted dcache lines to memory
module dcache_wb_buffer
  import cache_defs::*;
#(
  parameter int DEPTH  = WBB_DEPTH,
  parameter int ADDR_W = WBB_ADDR_W,
  parameter int LINE_W = WBB_LINE_W,
  parameter int OFF_W  = WBB_OFF_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [ADDR_W-1:0] enq_addr_i,
  input  logic [LINE_W-1:0] enq_data_i,
  input  logic [ADDR_W-1:0] lkup_addr_i,
  output logic              lkup_hit_o,
  output logic [LINE_W-1:0] lkup_data_o,
  output logic              mem_wr_req_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [LINE_W-1:0] mem_wr_data_o,
  input  logic              mem_wr_ack_i,
  output logic              empty_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0][TAG_W-1:0]  tag_q;
  logic [DEPTH-1:0][LINE_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  wbb_state_e                   state_q;

  logic             busy, pop, enq_fire, alloc, coal;
  logic [DEPTH-1:0] lock_mask;
  logic [TAG_W-1:0] enq_tag, lkup_tag;

  logic [DEPTH-1:0] co_match, lk_match;
  logic             co_hit, lk_hit, co_lhit, lk_lhit;
  logic [PTR_W-1:0] co_idx, lk_idx;

  // Offset bits of both addresses are don't-care
  logic unused_offsets;
  assign unused_offsets = ^{enq_addr_i[OFF_W-1:0], lkup_addr_i[OFF_W-1:0],
                            co_match, lk_match, co_lhit};

  assign enq_tag   = enq_addr_i[ADDR_W-1:OFF_W];
  assign lkup_tag  = lkup_addr_i[ADDR_W-1:OFF_W];
  assign busy      = (state_q == WBB_BUSY);
  assign lock_mask = busy ? (DEPTH'(1) << head_q) : '0;

  wbb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coalesce_match (
    .tag_i        (enq_tag),
    .tags_i       (tag_q),
    .valid_i      (valid_q),
    .lock_i       (lock_mask),
    .match_o      (co_match),
    .hit_o        (co_hit),
    .idx_o        (co_idx),
    .locked_hit_o (co_lhit)
  );

  wbb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup_match (
    .tag_i        (lkup_tag),
    .tags_i       (tag_q),
    .valid_i      (valid_q),
    .lock_i       (lock_mask),
    .match_o      (lk_match),
    .hit_o        (lk_hit),
    .idx_o        (lk_idx),
    .locked_hit_o (lk_lhit)
  );

  assign enq_ready_o = (count_q < DEPTH_C) || co_hit;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign alloc       = enq_fire && !co_hit;
  assign coal        = enq_fire && co_hit;
  assign pop         = busy && mem_wr_ack_i;

  // Next-state for valid bits, pointers and occupancy
  always_comb begin
    valid_d = valid_q;
    if (pop)   valid_d[head_q] = 1'b0;
    if (alloc) valid_d[tail_q] = 1'b1;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(alloc);
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  // Occupancy bookkeeping; reset discards every entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; only read when the matching valid bit is set
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= enq_tag;
      data_q[tail_q] <= enq_data_i;
    end
    if (coal) begin
      data_q[co_idx] <= enq_data_i;
    end
  end

  // Drain FSM: hold the head request until memory acks, then move on or idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WBB_IDLE;
    end else begin
      case (state_q)
        WBB_IDLE: if (count_q != '0) state_q <= WBB_BUSY;
        WBB_BUSY: if (pop && (count_d == '0)) state_q <= WBB_IDLE;
        default:  state_q <= WBB_IDLE;
      endcase
    end
  end

  assign mem_wr_req_o  = busy;
  assign mem_wr_addr_o = busy ? {tag_q[head_q], {OFF_W{1'b0}}} : '0;
  assign mem_wr_data_o = busy ? data_q[head_q] : '0;

  // Unlocked entry has the freshest copy; fall back to the in-flight head
  always_comb begin
    lkup_hit_o  = lk_hit || lk_lhit;
    lkup_data_o = '0;
    if (lk_hit)       lkup_data_o = data_q[lk_idx];
    else if (lk_lhit) lkup_data_o = data_q[head_q];
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb/tb_dcache_wb_buffer.sv - directed self-checking bench for dcache_wb_buffer
module tb_dcache_wb_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enq_valid_i;
  logic         enq_ready_o;
  logic [31:0]  enq_addr_i;
  logic [127:0] enq_data_i;
  logic [31:0]  lkup_addr_i;
  logic         lkup_hit_o;
  logic [127:0] lkup_data_o;
  logic         mem_wr_req_o;
  logic [31:0]  mem_wr_addr_o;
  logic [127:0] mem_wr_data_o;
  logic         mem_wr_ack_i;
  logic         empty_o;
  logic         full_o;
  logic [2:0]   count_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_wb_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enq_valid_i   (enq_valid_i),
    .enq_ready_o   (enq_ready_o),
    .enq_addr_i    (enq_addr_i),
    .enq_data_i    (enq_data_i),
    .lkup_addr_i   (lkup_addr_i),
    .lkup_hit_o    (lkup_hit_o),
    .lkup_data_o   (lkup_data_o),
    .mem_wr_req_o  (mem_wr_req_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_wr_ack_i  (mem_wr_ack_i),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{a}};
  endfunction

  logic [31:0] exp_addrs [4];

  initial begin
    rst_n = 1'b0; enq_valid_i = 1'b0; enq_addr_i = '0; enq_data_i = '0;
    lkup_addr_i = '0; mem_wr_ack_i = 1'b0;
    tick(); tick();
    check("rst_ready", enq_ready_o, 1);
    check("rst_hit",   lkup_hit_o, 0);
    check("rst_ldata", lkup_data_o, 0);
    check("rst_req",   mem_wr_req_o, 0);
    check("rst_waddr", mem_wr_addr_o, 0);
    check("rst_wdata", mem_wr_data_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full",  full_o, 0);
    check("rst_count", count_o, 0);
    rst_n = 1'b1;
    tick();

    // Single line, ack on first request cycle
    enq_valid_i = 1'b1; enq_addr_i = 32'h0000_1230; enq_data_i = {16{8'hA5}};
    #1 check("t1_ready", enq_ready_o, 1);
    tick();
    enq_valid_i = 1'b0;
    check("t1_count1", count_o, 1);
    check("t1_req_n",  mem_wr_req_o, 0);
    tick();
    check("t1_req_n1", mem_wr_req_o, 1);
    check("t1_addr",   mem_wr_addr_o, 32'h0000_1230);
    check("t1_data",   mem_wr_data_o, {16{8'hA5}});
    mem_wr_ack_i = 1'b1;
    tick();
    mem_wr_ack_i = 1'b0;
    check("t1_empty",  empty_o, 1);
    check("t1_req_off", mem_wr_req_o, 0);

    // Fill four distinct lines, then drain in FIFO order across pointer wrap
    for (int i = 0; i < 4; i++) begin
      enq_valid_i = 1'b1; enq_addr_i = 32'h1000 * (i + 1); enq_data_i = pat(32'h1000 * (i + 1));
      tick();
    end
    enq_valid_i = 1'b0;
    check("t2_full",  full_o, 1);
    check("t2_count", count_o, 4);
    enq_valid_i = 1'b1; enq_addr_i = 32'h5000;
    #1 check("t2_ready_new", enq_ready_o, 0);
    enq_addr_i = 32'h2008;
    #1 check("t2_ready_coal", enq_ready_o, 1);
    enq_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), mem_wr_addr_o, 32'h1000 * (i + 1));
      check($sformatf("t2_data%0d", i), mem_wr_data_o, pat(32'h1000 * (i + 1)));
      mem_wr_ack_i = 1'b1;
      tick();
    end
    mem_wr_ack_i = 1'b0;
    check("t2_empty", empty_o, 1);
    check("t2_req",   mem_wr_req_o, 0);

    // Coalesce behind a locked head, plus lookup
    enq_valid_i = 1'b1; enq_addr_i = 32'h300; enq_data_i = pat(32'hAAAA_0300);
    tick();
    enq_addr_i = 32'h100; enq_data_i = pat(32'hD1D1_0100);
    tick();
    enq_data_i = pat(32'hD2D2_0100);
    #1 check("t3_ready", enq_ready_o, 1);
    tick();
    enq_valid_i = 1'b0;
    check("t3_count", count_o, 2);
    lkup_addr_i = 32'h104;
    #1 check("t4_hit",  lkup_hit_o, 1);
    check("t4_data", lkup_data_o, pat(32'hD2D2_0100));
    lkup_addr_i = 32'h200;
    #1 check("t4_miss_hit",  lkup_hit_o, 0);
    check("t4_miss_data", lkup_data_o, 0);
    lkup_addr_i = 32'h30C;
    #1 check("t4_head_hit",  lkup_hit_o, 1);
    check("t4_head_data", lkup_data_o, pat(32'hAAAA_0300));
    lkup_addr_i = 32'h0;
    check("t3_addr0", mem_wr_addr_o, 32'h300);
    mem_wr_ack_i = 1'b1;
    tick();
    check("t3_addr1", mem_wr_addr_o, 32'h100);
    check("t3_data1", mem_wr_data_o, pat(32'hD2D2_0100));
    tick();
    mem_wr_ack_i = 1'b0;
    check("t3_empty", empty_o, 1);

    // Full buffer: enqueue refused on the pop edge, accepted next cycle
    exp_addrs[0] = 32'hB000; exp_addrs[1] = 32'hC000;
    exp_addrs[2] = 32'hD000; exp_addrs[3] = 32'hE000;
    for (int i = 0; i < 4; i++) begin
      enq_valid_i = 1'b1; enq_addr_i = 32'hA000 + 32'h1000 * i; enq_data_i = pat(32'hA000 + 32'h1000 * i);
      tick();
    end
    enq_addr_i = 32'hE000; enq_data_i = pat(32'hE000);
    mem_wr_ack_i = 1'b1;
    #1 check("t5_ready_full", enq_ready_o, 0);
    tick();
    mem_wr_ack_i = 1'b0;
    check("t5_count3", count_o, 3);
    #1 check("t5_ready_next", enq_ready_o, 1);
    tick();
    enq_valid_i = 1'b0;
    check("t5_count4", count_o, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_addr%0d", i), mem_wr_addr_o, exp_addrs[i]);
      mem_wr_ack_i = 1'b1;
      tick();
    end
    mem_wr_ack_i = 1'b0;
    check("t5_empty", empty_o, 1);

    // Reset while BUSY with two entries
    enq_valid_i = 1'b1; enq_addr_i = 32'h700; enq_data_i = pat(32'h700);
    tick();
    enq_addr_i = 32'h800; enq_data_i = pat(32'h800);
    tick();
    enq_valid_i = 1'b0;
    check("t6_busy",  mem_wr_req_o, 1);
    check("t6_count", count_o, 2);
    rst_n = 1'b0;
    tick();
    check("t6_req",   mem_wr_req_o, 0);
    check("t6_count0", count_o, 0);
    check("t6_empty", empty_o, 1);
    lkup_addr_i = 32'h700;
    #1 check("t6_lkup", lkup_hit_o, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
